// File: rtl/timer_pkg.sv
// Shared constants for the stopwatch: FSM state encoding, prescaler divide ratio and
// counter width helpers used by the sequencer, counter datapath and display decoder.
package timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int CLK_HZ_DEF       = 50_000_000;
  localparam int TICK_HZ_DEF      = 100;
  localparam int DEBOUNCE_CYC_DEF = 500_000;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int TICK_DIV_DEF  = tick_div(CLK_HZ_DEF, TICK_HZ_DEF);
  localparam int PRESC_W_DEF   = $clog2(TICK_DIV_DEF);
  localparam int DEB_CNT_W_DEF = cnt_width(DEBOUNCE_CYC_DEF);

endpackage

// File: rtl/key_debounce.sv
// One push-button path: two-flop synchronizer, stability counter and a one-cycle
// press pulse on an accepted high-to-low change of the (active-low) key level.
module key_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differ;
  logic             w_accept;

  // Disagreement with the accepted level, and the point where it has lasted long enough.
  always_comb begin
    w_differ = r_sync2 ^ r_stable;
    w_accept = (r_cnt == CNT_MAX);
  end

  // Released level is 1 so that a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      if (w_accept) begin
        // Only the 1->0 flip is a press; releases flip silently.
        r_stable <= ~r_stable;
        r_press  <= r_stable;
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_press <= 1'b0;
        if (w_differ) begin
          r_cnt <= r_cnt + CNT_ONE;
        end else begin
          r_cnt <= {CNT_W{1'b0}};
        end
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch sequencer: debounces start/pause and clear keys, runs the IDLE/RUN/PAUSE/FULL
// state machine and emits the prescaled count-enable tick and the datapath clear pulse.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int TICK_HZ      = TICK_HZ_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       at_max,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int                 TICK_DIV   = tick_div(CLK_HZ, TICK_HZ);
  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic               w_start_evt;
  logic               w_clear_evt;

  logic [1:0]         r_state;
  logic [PRESC_W-1:0] r_presc;
  logic               r_tick;
  logic               r_clr;
  logic               r_running;

  logic [1:0]         w_state_nxt;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic               w_tick_nxt;
  logic               w_clr_nxt;
  logic               w_running_nxt;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_start (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (KEY0),
    .press (w_start_evt)
  );

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (KEY1),
    .press (w_clear_evt)
  );

  // Next state, prescaler and pulse decode; clear outranks everything, then at_max, then start.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_clr_nxt   = 1'b0;
    if (w_clear_evt) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = {PRESC_W{1'b0}};
      w_clr_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_evt) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (at_max) begin
            w_state_nxt = ST_FULL;
          end else if (w_start_evt) begin
            // Prescaler is frozen on the pausing cycle so resume finishes the same period.
            w_state_nxt = ST_PAUSE;
          end else if (r_presc == PRESC_LAST) begin
            w_presc_nxt = {PRESC_W{1'b0}};
            w_tick_nxt  = 1'b1;
          end else begin
            w_presc_nxt = r_presc + PRESC_ONE;
          end
        end
        ST_PAUSE: begin
          if (w_start_evt) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_FULL: begin
          w_state_nxt = ST_FULL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_presc_nxt = {PRESC_W{1'b0}};
        end
      endcase
    end
    w_running_nxt = (w_state_nxt == ST_RUN);
  end

  // State, prescaler and every output are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= {PRESC_W{1'b0}};
      r_tick    <= 1'b0;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
      r_clr     <= w_clr_nxt;
      r_running <= w_running_nxt;
    end
  end

  assign tick    = r_tick;
  assign clr     = r_clr;
  assign running = r_running;
  assign state   = r_state;

endmodule
